// File: rtl/cache_l2_pkg.sv
// ---------------------------------------------------------------------------
// cache_l2_pkg
// Shared types and helpers for the set-associative L2 cache.
//   cache_l2_state_t : controller states
//   calc_idx_w       : index width for a given set count
//   calc_tag_w       : tag width for a given address width and set count
//   onehot_to_idx    : priority encoder, lowest set bit wins
// ---------------------------------------------------------------------------
package cache_l2_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOOKUP    = 3'd1,
        MISS_REQ  = 3'd2,
        MISS_WAIT = 3'd3,
        WR_REQ    = 3'd4,
        RESP      = 3'd5
    } cache_l2_state_t;

    // Widest associativity the encoder below has to handle.
    localparam int MAX_WAYS = 8;

    function automatic int calc_idx_w(input int sets);
        return $clog2(sets);
    endfunction

    // Two low address bits are the byte offset and never reach the tag.
    function automatic int calc_tag_w(input int addr_w, input int sets);
        return addr_w - $clog2(sets) - 2;
    endfunction

    // Lowest-index set bit wins, so a corrupted multi-hit still picks one way
    // and the same helper can pick the first free way from an invalid mask.
    function automatic logic [2:0] onehot_to_idx(input logic [MAX_WAYS-1:0] vec);
        logic [2:0] idx;
        idx = '0;
        for (int i = MAX_WAYS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/plru_tree.sv
// ---------------------------------------------------------------------------
// plru_tree
// Combinational tree pseudo-LRU helper for one cache set.
// Tree bits are heap ordered: node n has children 2n+1 (left) and 2n+2
// (right). A bit of 0 means the victim lies in the left subtree.
//   tree_i      : current tree bits of the set
//   touch_way_i : way being accessed
//   victim_o    : way the current tree points at
//   tree_o      : tree bits after touching touch_way_i
// ---------------------------------------------------------------------------
module plru_tree #(
    parameter  int WAYS  = 2,
    localparam int WAY_W = $clog2(WAYS)
) (
    input  logic [WAYS-2:0]  tree_i,
    input  logic [WAY_W-1:0] touch_way_i,
    output logic [WAY_W-1:0] victim_o,
    output logic [WAYS-2:0]  tree_o
);

    // Walk from the root following the stored bits to find the victim, and
    // separately walk the touched way's path flipping each bit to point away.
    always_comb begin
        int   node_v;
        int   node_t;
        logic dir;
        victim_o = '0;
        tree_o   = tree_i;
        node_v   = 0;
        node_t   = 0;
        dir      = 1'b0;
        for (int l = 0; l < WAY_W; l++) begin
            dir                     = tree_i[node_v];
            victim_o[WAY_W - 1 - l] = dir;
            node_v                  = 2 * node_v + (dir ? 2 : 1);
        end
        for (int l = 0; l < WAY_W; l++) begin
            dir            = touch_way_i[WAY_W - 1 - l];
            tree_o[node_t] = ~dir;
            node_t         = 2 * node_t + (dir ? 2 : 1);
        end
    end

endmodule

// File: rtl/cache_l2_assoc.sv
// ---------------------------------------------------------------------------
// cache_l2_assoc
// N-way set-associative, write-through, write-no-allocate L2 cache with one
// outstanding request, tree-PLRU replacement, global flush and saturating
// hit/miss counters.
// Ports:
//   clk, reset (async, active-low)
//   req_*      : bus request (valid/ready) and one-cycle response pulse
//   mem_*      : memory request (valid/ready) and read-data return
//   flush      : invalidate all lines (deferred to IDLE when busy)
//   busy       : controller not in IDLE
//   hit_cnt, miss_cnt : saturating statistics
// ---------------------------------------------------------------------------
module cache_l2_assoc
    import cache_l2_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int SETS   = 128,
    parameter int WAYS   = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              flush,
    output logic              busy,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    localparam int IDX_W = calc_idx_w(SETS);
    localparam int TAG_W = calc_tag_w(ADDR_W, SETS);
    localparam int WAY_W = $clog2(WAYS);

    cache_l2_state_t   state_q, state_d;
    logic              we_q;
    logic [ADDR_W-1:2] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              hit_q, hit_d;
    logic              flush_pend_q, flush_pend_d;
    logic [CNT_W-1:0]  hit_cnt_q, miss_cnt_q;

    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAYS-2:0]   plru_q  [SETS];
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [DATA_W-1:0] data_q  [SETS][WAYS];

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [WAYS-1:0]   hit_vec;
    logic              any_hit, any_inv;
    logic [WAY_W-1:0]  hit_way, inv_way, fill_way, touch_way, plru_victim;
    logic [WAYS-2:0]   plru_next;
    logic              accept, do_flush, hit_inc, miss_inc, data_wr, fill, touch;
    logic              addr_lsb_unused;

    assign addr_lsb_unused = ^req_addr[1:0];

    assign idx = addr_q[IDX_W+1:2];
    assign tag = addr_q[ADDR_W-1:IDX_W+2];

    always_comb begin
        hit_vec = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_vec[w] = valid_q[idx][w] && (tag_q[idx][w] == tag);
        end
    end

    assign any_hit   = |hit_vec;
    assign any_inv   = ~&valid_q[idx];
    assign hit_way   = WAY_W'(onehot_to_idx(MAX_WAYS'(hit_vec)));
    assign inv_way   = WAY_W'(onehot_to_idx(MAX_WAYS'(~valid_q[idx])));
    // Free ways are consumed before PLRU gets a say.
    assign fill_way  = any_inv ? inv_way : plru_victim;
    assign touch_way = (state_q == MISS_WAIT) ? fill_way : hit_way;

    plru_tree #(.WAYS(WAYS)) u_plru (
        .tree_i      (plru_q[idx]),
        .touch_way_i (touch_way),
        .victim_o    (plru_victim),
        .tree_o      (plru_next)
    );

    // Next-state and per-cycle action strobes. A flush seen while busy is
    // remembered and applied on the first IDLE cycle, where it also blocks
    // acceptance of a new request.
    always_comb begin
        state_d      = state_q;
        rdata_d      = rdata_q;
        hit_d        = hit_q;
        flush_pend_d = flush_pend_q | flush;
        accept       = 1'b0;
        do_flush     = 1'b0;
        hit_inc      = 1'b0;
        miss_inc     = 1'b0;
        data_wr      = 1'b0;
        fill         = 1'b0;
        touch        = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush || flush_pend_q) begin
                    do_flush     = 1'b1;
                    flush_pend_d = 1'b0;
                end else if (req_valid) begin
                    accept  = 1'b1;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                hit_d = any_hit;
                if (any_hit) begin
                    hit_inc = 1'b1;
                    touch   = 1'b1;
                    if (we_q) begin
                        data_wr = 1'b1;
                        rdata_d = '0;
                        state_d = WR_REQ;
                    end else begin
                        rdata_d = data_q[idx][hit_way];
                        state_d = RESP;
                    end
                end else begin
                    miss_inc = 1'b1;
                    rdata_d  = '0;
                    state_d  = we_q ? WR_REQ : MISS_REQ;
                end
            end
            MISS_REQ: begin
                if (mem_req_ready) state_d = MISS_WAIT;
            end
            MISS_WAIT: begin
                if (mem_rvalid) begin
                    fill    = 1'b1;
                    touch   = 1'b1;
                    rdata_d = mem_rdata;
                    state_d = RESP;
                end
            end
            WR_REQ: begin
                if (mem_req_ready) state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller state, captured request and saturating counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            hit_q        <= 1'b0;
            flush_pend_q <= 1'b0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            rdata_q      <= rdata_d;
            hit_q        <= hit_d;
            flush_pend_q <= flush_pend_d;
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr[ADDR_W-1:2];
                wdata_q <= req_wdata;
            end
            if (hit_inc && (hit_cnt_q != '1)) hit_cnt_q <= hit_cnt_q + CNT_W'(1);
            if (miss_inc && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
        end
    end

    // Valid and PLRU bits are the only array state that needs a reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else if (do_flush) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            if (fill) valid_q[idx][fill_way] <= 1'b1;
            if (touch) plru_q[idx] <= plru_next;
        end
    end

    // Tag and data storage; contents are meaningless until the valid bit is set.
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_q[idx][fill_way]  <= tag;
            data_q[idx][fill_way] <= mem_rdata;
        end else if (data_wr) begin
            data_q[idx][hit_way] <= wdata_q;
        end
    end

    assign req_ready     = (state_q == IDLE) && !flush && !flush_pend_q;
    assign busy          = (state_q != IDLE);
    assign resp_valid    = (state_q == RESP);
    assign resp_hit      = (state_q == RESP) && hit_q;
    assign resp_rdata    = (state_q == RESP) ? rdata_q : '0;
    assign mem_req_valid = (state_q == MISS_REQ) || (state_q == WR_REQ);
    assign mem_we        = (state_q == WR_REQ);
    assign mem_addr      = {addr_q, 2'b00};
    assign mem_wdata     = (state_q == WR_REQ) ? wdata_q : '0;
    assign hit_cnt       = hit_cnt_q;
    assign miss_cnt      = miss_cnt_q;

endmodule
